// File: rtl/helen_loader_pkg.sv
// ---------------------------------------------------------------------------
// helen_loader_pkg
//   Shared definitions for the on-chip loader: FSM state type, default RAM
//   geometry and the number of byte lanes packed into one RAM word.
// ---------------------------------------------------------------------------
package helen_loader_pkg;

    localparam int DEFAULT_ADDR_W = 13;
    localparam int DEFAULT_DEPTH  = 8192;
    localparam int LANES          = 4;
    localparam int LANE_W         = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage : helen_loader_pkg

// File: rtl/helen_byte_packer.sv
// ---------------------------------------------------------------------------
// helen_byte_packer
//   Packs a byte stream little-endian into a 32-bit word. Each accepted byte
//   lands in the current lane, sets that lane's byteenable bit and advances
//   the lane modulo 4. A clear empties the word and returns to lane 0.
//
// Ports
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : empty the pack register / byteenables, lane back to 0
//   accept       : byte_in is stored this cycle
//   byte_in      : stream byte
//   word         : packed word (unfilled lanes read as 0)
//   byteenable   : lanes holding valid bytes
//   last_lane    : current lane is lane 3 (the next accept fills the word)
// ---------------------------------------------------------------------------
module helen_byte_packer
    import helen_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    output logic [8*LANES-1:0] word,
    output logic [LANES-1:0]  byteenable,
    output logic              last_lane
);

    logic [8*LANES-1:0] pack_q;
    logic [LANES-1:0]   be_q;
    logic [LANE_W-1:0]  lane_q;

    // NOTE: the pack register is reset along with the lane state; it is a
    // handful of flops, and a defined reset value keeps mem_writedata at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pack_q <= '0;
            be_q   <= '0;
            lane_q <= '0;
        end else if (clear) begin
            pack_q <= '0;
            be_q   <= '0;
            lane_q <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every flop updates from the
            // pre-edge value of lane_q, independent of statement order.
            pack_q[8*lane_q +: 8] <= byte_in;
            be_q[lane_q]          <= 1'b1;
            lane_q                <= lane_q + LANE_W'(1);
        end
    end

    assign word       = pack_q;
    assign byteenable = be_q;
    assign last_lane  = (lane_q == LANE_W'(LANES - 1));

endmodule : helen_byte_packer

// File: rtl/helen_onchip_loader.sv
// ---------------------------------------------------------------------------
// helen_onchip_loader
//   Streams bytes into an on-chip 32-bit RAM. Bytes are packed four to a
//   word and written one cycle after the accept that completes a word (or
//   carries s_last). Writes proceed upward from start_addr; a load that runs
//   past the last RAM word sets the sticky err flag and the remaining bytes
//   are drained without writing.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   start, start_addr : begin a load at start_addr (honoured only when idle)
//   s_data, s_valid,
//   s_ready, s_last   : byte stream with handshake, s_last marks final byte
//   mem_*             : RAM write port (mem_clken tied high)
//   busy              : load in progress
//   done              : one-cycle pulse at load completion
//   err               : sticky overflow flag, cleared by the next start
//   words_written     : RAM writes issued in the current load
// ---------------------------------------------------------------------------
module helen_onchip_loader
    import helen_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              last_q;        // pending write carries s_last
    logic [ADDR_W-1:0] addr_hold_q;   // mem_address outside WRITE
    logic [31:0]       data_hold_q;   // mem_writedata outside WRITE
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   words_q;

    logic              accept;
    logic              start_ok;
    logic              pk_clear;
    logic              pk_accept;
    logic              pk_last_lane;
    logic              word_ready;
    logic              at_top;
    logic [31:0]       pk_word;
    logic [3:0]        pk_be;

    assign accept     = s_valid && s_ready;
    assign start_ok   = (state_q == ST_IDLE) && start;
    assign pk_accept  = accept && (state_q == ST_PACK);
    assign word_ready = pk_accept && (pk_last_lane || s_last);
    // The packer empties at the end of every WRITE cycle and on a new load.
    assign pk_clear   = start_ok || (state_q == ST_WRITE);
    assign at_top     = (ptr_q == ADDR_W'(DEPTH - 1));

    helen_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .accept     (pk_accept),
        .byte_in    (s_data),
        .word       (pk_word),
        .byteenable (pk_be),
        .last_lane  (pk_last_lane)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d        = state_q;
        s_ready        = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = 4'b0000;
        mem_address    = addr_hold_q;
        mem_writedata  = data_hold_q;
        busy           = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_PACK;
            end
            ST_PACK: begin
                s_ready = 1'b1;
                if (word_ready) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_byteenable = pk_be;
                mem_address    = ptr_q;
                mem_writedata  = pk_word;
                if (last_q)      state_d = ST_IDLE;
                else if (at_top) state_d = ST_DRAIN;
                else             state_d = ST_PACK;
            end
            ST_DRAIN: begin
                s_ready = 1'b1;
                if (accept && s_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointer, counters, status and held RAM bus values
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            last_q      <= 1'b0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= '0;
        end else begin
            done_q <= 1'b0;

            if (start_ok) begin
                ptr_q   <= start_addr;
                err_q   <= 1'b0;
                words_q <= '0;
            end

            if (word_ready) last_q <= s_last;

            if (state_q == ST_WRITE) begin
                words_q     <= words_q + {{ADDR_W{1'b0}}, 1'b1};
                addr_hold_q <= ptr_q;
                data_hold_q <= pk_word;
                if (last_q)
                    done_q <= 1'b1;
                else if (at_top)
                    err_q  <= 1'b1;   // pointer never wraps past the last word
                else
                    ptr_q  <= ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end

            if ((state_q == ST_DRAIN) && accept && s_last) done_q <= 1'b1;
        end
    end

    assign done          = done_q;
    assign err           = err_q;
    assign words_written = words_q;
    assign mem_clken     = 1'b1;

endmodule : helen_onchip_loader

// File: tb/tb_helen_onchip_loader.sv
// ---------------------------------------------------------------------------
// tb_helen_onchip_loader
//   Self-checking bench: a table of directed loads, hand-written reset and
//   power-up sequences, and randomized loads, all compared against a
//   word-level model of where each byte must land in RAM.
// ---------------------------------------------------------------------------
module tb_helen_onchip_loader;
    import helen_loader_pkg::*;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 8192;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_writedata;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_clken;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_written;

    helen_onchip_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_addr     (start_addr),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_last         (s_last),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_clken      (mem_clken),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .words_written  (words_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wr_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                n;
        logic [7:0]        b0;
        logic [7:0]        step;
        int                mode;      // 0 always valid, 1 toggling, 2 random
        int                poke;      // byte index at which start is re-pulsed
        int                exp_words;
        logic              exp_err;
        logic [31:0]       exp_data0;
        logic [3:0]        exp_be0;
    } vec_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] tx[$];
    logic       exp_err;
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         done_cnt  = 0;
    int         anomalies = 0;

    // Observe the RAM port and handshake away from the rising edge.
    always @(negedge clk) begin
        if (mem_write) got_q.push_back(wr_t'{mem_address, mem_writedata, mem_byteenable});
        if (done) done_cnt++;
        // While busy, s_ready must be low exactly in the write cycle.
        if (busy && (s_ready == mem_write)) anomalies++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word-level model: byte k goes to word start+k/4, lane k%4; words past
    // the end of RAM are never written and flag an overflow.
    task automatic model(input logic [ADDR_W-1:0] addr);
        int  n      = tx.size();
        int  nwords = (n + 3) / 4;
        wr_t w;
        exp_q.delete();
        exp_err = (int'(addr) + nwords - 1) > (DEPTH - 1);
        for (int k = 0; k < nwords; k++) begin
            if (int'(addr) + k <= DEPTH - 1) begin
                w.addr = ADDR_W'(int'(addr) + k);
                w.data = '0;
                w.be   = '0;
                for (int b = 0; b < 4; b++) begin
                    if (4 * k + b < n) begin
                        w.data[8*b +: 8] = tx[4*k + b];
                        w.be[b]          = 1'b1;
                    end
                end
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic run_load(input logic [ADDR_W-1:0] addr, input int mode, input int poke);
        int idx   = 0;
        int cyc   = 0;
        bit acc;
        bit v;
        bit poked = 0;
        got_q.delete();
        done_cnt  = 0;
        anomalies = 0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = addr;
        @(posedge clk); #1;
        start = 1'b0; start_addr = ADDR_W'($urandom);
        while (idx < tx.size() && cyc < 400) begin
            v       = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = v ? tx[idx] : 8'($urandom);
            s_last  = v && (idx == tx.size() - 1);
            if (v && !poked && poke == idx) begin
                start      = 1'b1;
                start_addr = 13'h155;
                poked      = 1;
            end
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) idx++;
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("bytes_accepted", idx, tx.size());
        cyc = 0;
        while (done_cnt == 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
    endtask

    task automatic compare_load(input string tag, input logic [ADDR_W-1:0] addr);
        int m;
        model(addr);
        check({tag, ".nwrites"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check({tag, ".addr"}, got_q[i].addr, exp_q[i].addr);
            check({tag, ".data"}, got_q[i].data, exp_q[i].data);
            check({tag, ".be"},   got_q[i].be,   exp_q[i].be);
        end
        check({tag, ".words_written"}, words_written, exp_q.size());
        check({tag, ".err"},      err, exp_err);
        check({tag, ".done_cnt"}, done_cnt, 1);
        check({tag, ".idle"},     {busy, mem_write, mem_chipselect}, 3'b000);
        check({tag, ".ready_ok"}, anomalies, 0);
        if (exp_q.size() > 0)
            check({tag, ".addr_hold"}, mem_address, exp_q[exp_q.size()-1].addr);
    endtask

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{13'h010,  8, 8'h01, 8'h01, 0, -1, 2, 1'b0, 32'h04030201, 4'b1111};
        vecs[1] = '{13'h020,  3, 8'hAA, 8'h11, 0, -1, 1, 1'b0, 32'h00CCBBAA, 4'b0111};
        vecs[2] = '{13'h1FFF, 6, 8'h11, 8'h01, 0, -1, 1, 1'b1, 32'h14131211, 4'b1111};
        vecs[3] = '{13'h050,  4, 8'h21, 8'h01, 1, -1, 1, 1'b0, 32'h24232221, 4'b1111};
        vecs[4] = '{13'h040,  8, 8'h31, 8'h01, 0,  2, 2, 1'b0, 32'h34333231, 4'b1111};
        vecs[5] = '{13'h1FFE, 5, 8'h41, 8'h01, 2, -1, 2, 1'b0, 32'h44434241, 4'b1111};
        vecs[6] = '{13'h1FFF, 4, 8'h61, 8'h01, 0, -1, 1, 1'b0, 32'h64636261, 4'b1111};
        vecs[7] = '{13'h000,  1, 8'h7E, 8'h00, 0, -1, 1, 1'b0, 32'h0000007E, 4'b0001};

        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        s_data     = '0;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        #12;
        check("por.ctrl", {s_ready, mem_chipselect, mem_write, done, busy, err}, 6'b0);
        check("por.bus",  {mem_address, mem_writedata, mem_byteenable}, '0);
        check("por.words", words_written, 0);
        check("por.clken", mem_clken, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed table.
        for (int r = 0; r < 8; r++) begin
            tx.delete();
            for (int k = 0; k < vecs[r].n; k++) tx.push_back(8'(vecs[r].b0 + 8'(k) * vecs[r].step));
            run_load(vecs[r].addr, vecs[r].mode, vecs[r].poke);
            check($sformatf("vec%0d.words", r), words_written, vecs[r].exp_words);
            check($sformatf("vec%0d.err", r),   err, vecs[r].exp_err);
            if (got_q.size() > 0) begin
                check($sformatf("vec%0d.data0", r), got_q[0].data, vecs[r].exp_data0);
                check($sformatf("vec%0d.be0", r),   got_q[0].be,   vecs[r].exp_be0);
            end else begin
                check($sformatf("vec%0d.any_write", r), 0, 1);
            end
            compare_load($sformatf("vec%0d", r), vecs[r].addr);
        end

        // Reset after two accepted bytes: partial word abandoned.
        got_q.delete();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 13'h030;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int acc_n = 0;
            int cyc   = 0;
            s_valid = 1'b1;
            while (acc_n < 2 && cyc < 20) begin
                s_data = 8'hD0 + 8'(acc_n);
                @(negedge clk);
                if (s_ready) acc_n++;
                @(posedge clk); #1;
                cyc++;
            end
            check("rst.accepted", acc_n, 2);
        end
        s_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst.ctrl", {s_ready, mem_chipselect, mem_write, done, busy, err}, 6'b0);
        check("rst.bus",  {mem_address, mem_writedata, mem_byteenable}, '0);
        check("rst.words", words_written, 0);
        check("rst.clken", mem_clken, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst.no_write", got_q.size(), 0);
        reset = 1'b0;
        tx.delete();
        for (int k = 0; k < 6; k++) tx.push_back(8'hE0 + 8'(k));
        run_load(13'h030, 0, -1);
        compare_load("after_rst", 13'h030);

        // Randomized loads, biased toward the top of RAM.
        for (int t = 0; t < 25; t++) begin
            logic [ADDR_W-1:0] a;
            int                n;
            a = ($urandom_range(0, 3) == 0) ? ADDR_W'(DEPTH - int'($urandom_range(1, 4)))
                                            : ADDR_W'($urandom_range(0, DEPTH - 1));
            n = $urandom_range(1, 14);
            tx.delete();
            for (int k = 0; k < n; k++) tx.push_back(8'($urandom));
            run_load(a, $urandom_range(0, 2), -1);
            compare_load($sformatf("rnd%0d", t), a);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_helen_onchip_loader

// File: doc/helen_onchip_loader.md
HELEN_ONCHIP_LOADER -- requirements
Module: helen_onchip_loader

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 13, word-address width of the target RAM.
- DEPTH, default 8192, number of 32-bit words in the target RAM.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE.
- start_addr  in  ADDR_W  first word address; latched when start is honoured.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts the byte this cycle.
- s_last  in  1  qualifies the final byte of a load.
- mem_address  out  ADDR_W  RAM word address.
- mem_writedata  out  32  packed word.
- mem_byteenable  out  4  lanes holding valid bytes.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_clken  out  1  RAM clock enable; driven constant 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load completes.
- err  out  1  sticky overflow flag.
- words_written  out  ADDR_W+1  count of RAM writes issued in the current load.

Function
REQ-003 The state machine SHALL have four states: IDLE, PACK, WRITE and DRAIN.
REQ-004 IDLE: s_ready=0; start moves the FSM to PACK, sets ptr=start_addr, lane=0, clears err, and sets words_written=0.
REQ-005 PACK: s_ready=1; an accepted byte (s_valid&s_ready) is stored in lane `lane` (bits 8*lane+7:8*lane, little-endian), its byteenable bit is set, and lane increments mod 4.
REQ-006 PACK moves to WRITE on the accept that fills lane 3, or on an accept with s_last=1, whichever comes first.
REQ-007 WRITE lasts exactly one cycle:
- mem_chipselect=mem_write=1, mem_address=ptr, mem_byteenable=filled lanes, s_ready=0.
- Unfilled lanes of mem_writedata are 0.
REQ-008 After the WRITE cycle: words_written increments, the byteenable accumulator clears, and lane=0.
- If the write carried s_last: done pulses and the FSM returns to IDLE.
- Otherwise, if ptr==DEPTH-1: err is set and the FSM goes to DRAIN.
- Otherwise: ptr increments and the FSM returns to PACK.
REQ-009 Latency SHALL be one cycle: mem_write is asserted the cycle after the accept that triggers the write.
REQ-010 DRAIN: s_ready=1, accepted bytes are discarded, and no RAM writes occur; an accept with s_last pulses done and returns the FSM to IDLE.
REQ-011 The pointer SHALL NOT wrap; writes never occur outside start_addr..DEPTH-1.
REQ-012 start asserted outside IDLE SHALL be ignored.
REQ-013 s_last on the 4th lane SHALL produce exactly one write, with byteenable 4'b1111.
REQ-014 s_valid=0 in PACK SHALL hold all state (no timeout).
REQ-015 Outside WRITE, mem_chipselect=mem_write=0; mem_writedata and mem_address hold their last values.
REQ-016 err SHALL stay set until the next honoured start.

Reset
REQ-017 Asynchronous assertion of reset SHALL force all of the following:
- FSM to IDLE; ptr=0; lane=0; pack register=0; byteenable accumulator=0.
- s_ready=0, mem_chipselect=0, mem_write=0, mem_byteenable=0, mem_address=0, mem_writedata=0.
- done=0, busy=0, err=0, words_written=0.
- mem_clken=1.
REQ-018 Reset mid-load SHALL abandon the partial word with no write issued; deassertion resumes in IDLE.

Structure
REQ-019 Package helen_loader_pkg SHALL hold the FSM state type, ADDR_W and DEPTH defaults, and the lane-count constant (4).
REQ-020 Byte-lane packing (pack register, lane counter, byteenable accumulator) SHALL be one sub-module, helen_byte_packer; the FSM and pointer stay in the top.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- start_addr=0x010, 8 bytes 0x01..0x08, last on 0x08 -> writes 0x04030201@0x010 and 0x08070605@0x011, both be=1111; done; words_written=2.
- start_addr=0x020, 3 bytes 0xAA,0xBB,0xCC, last on 0xCC -> one write 0x00CCBBAA@0x020, be=0111; done; err=0.
- start_addr=0x1FFF, 6 bytes, last on 6th -> one write @0x1FFF, be=1111; err=1; bytes 5-6 drained; done; no write to 0x0000.
- s_valid toggling every other cycle, 4 bytes -> identical single write; s_ready low only in the WRITE cycle.
- start pulsed while busy -> ignored; ptr and words_written unchanged.
- reset asserted after 2 bytes accepted -> no write; all outputs at reset values; a new start then loads normally.
